// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: types and constants for the uio pin-bank arbiter.
//   arb_state_e : arbiter FSM states (IDLE, TURN, GRANT)
//   UIO_W       : width of the shared uio pin bank
//   CNT_W       : width of the per-grant beat counter
//   oe_byte()   : expands a one-bit direction into a full output-enable byte
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int UIO_W = 8;
  localparam int CNT_W = 8;

  // The pin bank is driven or released as a whole, never bit by bit.
  function automatic logic [UIO_W-1:0] oe_byte(input logic drive);
    return drive ? {UIO_W{1'b1}} : {UIO_W{1'b0}};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Ports:
//   req     in  NREQ   request vector
//   ptr     in  IDX_W  index of the highest-priority requester
//   win_oh  out NREQ   one-hot winner (all zero when no request)
//   win_idx out IDX_W  winner index (0 when no request)
//   win_any out 1      at least one request present
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  logic [IDX_W:0]   pos_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;

  // Walk from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    pos_s = '0;
    idx_s = '0;
    any_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos_s = {1'b0, ptr} + (IDX_W + 1)'(k);
      pos_s = (pos_s >= (IDX_W + 1)'(NREQ)) ? pos_s - (IDX_W + 1)'(NREQ) : pos_s;
      idx_s = req[pos_s[IDX_W-1:0]] ? pos_s[IDX_W-1:0] : idx_s;
      any_s = any_s | req[pos_s[IDX_W-1:0]];
    end
  end

  assign win_idx = idx_s;
  assign win_any = any_s;
  assign win_oh  = any_s ? ({{(NREQ - 1){1'b0}}, 1'b1} << idx_s) : {NREQ{1'b0}};

endmodule

// File: rtl/uio_port_arbiter.sv
// uio_port_arbiter: shares the 8-bit bidirectional uio pin bank between NREQ
// internal requesters with round-robin grants and a turnaround cycle between owners.
// Configuration macro: UIO_ARB_TURNAROUND_EN
//   defined     -> every new grant is preceded by one TURN cycle with uio_oe = 0
//   not defined -> grants move directly between owners (single-direction systems only)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           design enable; low forces release to IDLE
//   req/dir/last  per-requester request, direction (1 = drive), final-beat marker
//   wdata         per-requester write byte, slice i = wdata[8*i+7:8*i]
//   gnt           registered one-hot grant
//   uio_in        pin input path
//   uio_out/oe    registered pin output and output enable (all-ones or all-zeros)
//   rdata/rvalid  captured pin byte and its one-cycle strobe
//   busy          high whenever the arbiter is not IDLE
module uio_port_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [UIO_W*NREQ-1:0] wdata,
  input  logic [NREQ-1:0]       last,
  output logic [NREQ-1:0]       gnt,
  input  logic [UIO_W-1:0]      uio_in,
  output logic [UIO_W-1:0]      uio_out,
  output logic [UIO_W-1:0]      uio_oe,
  output logic [UIO_W-1:0]      rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

`ifdef UIO_ARB_TURNAROUND_EN
  localparam arb_state_e WIN_ST = TURN;
`else
  localparam arb_state_e WIN_ST = GRANT;
`endif

  arb_state_e       state_r, state_nx_s;
  logic [IDX_W-1:0] owner_r, owner_nx_s;
  logic [NREQ-1:0]  owner_oh_r, owner_oh_nx_s;
  logic [IDX_W-1:0] ptr_r, ptr_nx_s;
  logic             dir_r, dir_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [NREQ-1:0]  gnt_r;
  logic [UIO_W-1:0] uio_out_r, uio_oe_r, rdata_r;
  logic             rvalid_r, busy_r;

  logic [NREQ-1:0]  pick_req_s, pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             beat_s, release_s, enter_s;
  logic [UIO_W-1:0] wsel_s;

  // While granted, the current owner is excluded so a release only hands over to someone else.
  assign pick_req_s = (state_r == GRANT) ? (req & ~owner_oh_r) : req;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (pick_req_s),
    .ptr     (ptr_r),
    .win_oh  (pick_oh_s),
    .win_idx (pick_idx_s),
    .win_any (pick_any_s)
  );

  assign beat_s    = (state_r == GRANT) && ena && req[owner_r];
  // A missing request, the owner's last beat and the hold limit all collapse into one release.
  assign release_s = !req[owner_r] || last[owner_r] || (cnt_r == CNT_W'(HOLD_MAX - 1));
  assign enter_s   = (state_nx_s == GRANT) && ((state_r != GRANT) || release_s);
  assign dir_nx_s  = enter_s ? dir[owner_nx_s] : dir_r;
  assign ptr_nx_s  = (owner_nx_s == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : owner_nx_s + IDX_W'(1);

  // Select the owner's write byte.
  always_comb begin
    wsel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      wsel_s = (owner_r == IDX_W'(i)) ? wdata[UIO_W*i +: UIO_W] : wsel_s;
    end
  end

  // Next-state and next-owner selection.
  always_comb begin
    state_nx_s    = state_r;
    owner_nx_s    = owner_r;
    owner_oh_nx_s = owner_oh_r;
    if (!ena) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            owner_nx_s    = pick_idx_s;
            owner_oh_nx_s = pick_oh_s;
            state_nx_s    = WIN_ST;
          end else begin
            state_nx_s = IDLE;
          end
        end
        TURN: begin
          state_nx_s = GRANT;
        end
        GRANT: begin
          if (!release_s) begin
            state_nx_s = GRANT;
          end else if (pick_any_s) begin
            owner_nx_s    = pick_idx_s;
            owner_oh_nx_s = pick_oh_s;
            state_nx_s    = WIN_ST;
          end else begin
            state_nx_s = IDLE;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // FSM state and current-owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      owner_oh_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      owner_r    <= owner_nx_s;
      owner_oh_r <= owner_oh_nx_s;
    end
  end

  // Grant, pin drive, capture and per-grant bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r     <= '0;
      uio_oe_r  <= '0;
      uio_out_r <= '0;
      rdata_r   <= '0;
      rvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
      dir_r     <= 1'b0;
      ptr_r     <= '0;
    end else begin
      gnt_r    <= (state_nx_s == GRANT) ? owner_oh_nx_s : {NREQ{1'b0}};
      uio_oe_r <= (state_nx_s == GRANT) ? oe_byte(dir_nx_s) : {UIO_W{1'b0}};
      busy_r   <= (state_nx_s != IDLE);
      rvalid_r <= beat_s && !dir_r;
      if (enter_s) begin
        cnt_r <= '0;
        dir_r <= dir_nx_s;
        ptr_r <= ptr_nx_s;
      end else if (beat_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (beat_s && dir_r) begin
        uio_out_r <= wsel_s;
      end
      if (beat_s && !dir_r) begin
        rdata_r <= uio_in;
      end
    end
  end

  assign gnt     = gnt_r;
  assign uio_out = uio_out_r;
  assign uio_oe  = uio_oe_r;
  assign rdata   = rdata_r;
  assign rvalid  = rvalid_r;
  assign busy    = busy_r;

endmodule

// File: doc/uio_port_arbiter.md
# uio_port_arbiter

Shares the 8-bit bidirectional `uio` pin bank of `tt_um_mrmola` between `NREQ` internal requesters. Grants the bus round-robin, drives `uio_out`/`uio_oe` from the current owner, captures `uio_in` for input owners, and inserts a turnaround cycle between owners so two drivers never overlap. Sits between the top-level `uio_*` pins and the design's internal engines.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `HOLD_MAX`, 8: maximum beats per grant before forced release (1..255).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable; low forces release.
- `req`  in  NREQ  per-requester bus request; held until granted.
- `dir`  in  NREQ  per-requester direction: 1 = drive pins, 0 = read pins.
- `wdata`  in  8*NREQ  per-requester write byte; slice i = `wdata[8*i+7:8*i]`.
- `last`  in  NREQ  marks the owner's final beat.
- `gnt`  out  NREQ  one-hot grant, registered.
- `uio_in`  in  8  pin input path.
- `uio_out`  out  8  pin output path, registered.
- `uio_oe`  out  8  pin output enable, registered; all-ones or all-zeros only.
- `rdata`  out  8  captured pin byte for input owner.
- `rvalid`  out  1  one-cycle strobe, `rdata` valid.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, TURN, GRANT.
- IDLE: if `ena` and any `req`: pick winner by round-robin; go to TURN.
- TURN (one cycle): `uio_oe`=0, `gnt`=0; then GRANT with `gnt[w]`=1.
- GRANT: `dir[w]` latched on entry and held for the whole grant; `uio_oe` = 8'hFF if latched dir=1, else 8'h00.
- Beat = any cycle in GRANT with `req[w]`=1. Output beat: `uio_out` <= `wdata[w]`. Input beat: `rdata` <= `uio_in`, `rvalid`=1 next cycle.
- Beat counter 8 bits, cleared on grant entry. Release when: beat with `last[w]`=1; beat count reaches `HOLD_MAX`; `req[w]`=0 (no beat); or `ena`=0.
- On release: `gnt`=0 next edge; if other `req` pending, go to TURN with new winner, else IDLE (`uio_oe`=0). `uio_out` holds last value.
- Round-robin: priority starts at `(last_owner+1) mod NREQ`; pointer after reset = 0, so requester 0 wins first tie.
- `ena`=0 in any state: next edge -> IDLE, `gnt`=0, `uio_oe`=0, `rvalid`=0; pointer kept.
- Reset: state IDLE, `gnt`=0, `uio_out`=0, `uio_oe`=0, `rdata`=0, `rvalid`=0, `busy`=0, pointer 0, count 0.

## Timing
- `req` first seen at edge t (IDLE) -> TURN at t+1 -> `gnt` high after edge t+2.
- Output beat at edge t -> `uio_out` valid after t.
- Input beat: `uio_in` sampled at edge t -> `rdata`/`rvalid` valid after t, `rvalid` high one cycle.
- Final beat at t -> `gnt` low after t+1; next owner's `gnt` high after t+2 (one TURN cycle with `uio_oe`=0).
- Simultaneous `last` and `HOLD_MAX` -> single release. `req` dropping the same cycle as grant entry -> release with zero beats.

## Configuration
- `UIO_ARB_TURNAROUND_EN` defined: TURN state present as above (every new grant preceded by one cycle `uio_oe`=0).
- Not defined: TURN removed; IDLE/GRANT release goes straight to GRANT of the winner, `gnt` one cycle earlier; `uio_oe` switches directly between owners. Intended only for configurations where all requesters share one direction.

## Structure
- Package `uio_arb_pkg`: state enum (IDLE, TURN, GRANT), `UIO_W`=8, counter width constant.
- Sub-module `rr_pick`: combinational round-robin winner from `req` and pointer, outputs one-hot and index.

## Test plan
- Reset, `req`=4'b0001, `dir[0]`=1, `wdata[0]`=8'hA5, `last[0]`=1 -> `gnt`=0001 after two edges, `uio_out`=8'hA5, `uio_oe`=8'hFF, then `gnt`=0, `uio_oe`=0.
- `req`=4'b1111 all continuous, `last`=1 each beat -> grant order 0,1,2,3,0 with exactly one `uio_oe`=0 cycle between each.
- Requester 2 input, `uio_in`=8'h3C, three beats, `last` on third -> three `rvalid` pulses, `rdata`=8'h3C, `uio_oe`=0 throughout.
- `HOLD_MAX`=8, requester 1 never asserts `last` -> release after exactly 8 beats, requester 3 (pending) granted next.
- `ena` dropped mid-grant -> `gnt`=0, `uio_oe`=0, IDLE next edge; `rst_n` asserted mid-grant -> all outputs zero immediately.
- Build without `UIO_ARB_TURNAROUND_EN` -> `req` to `gnt` latency one edge, back-to-back owners with no idle cycle.
